// File: rtl/fpaddsub_issue_arbiter_if.sv
// rtl/fpaddsub_issue_arbiter_if.sv - requester, core and result signals of the FP add/sub issue arbiter
interface fpaddsub_issue_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_op;
    logic        core_issue;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_op;
    logic [31:0] core_result;
    logic        res0_valid;
    logic        res0_ready;
    logic [31:0] res0_data;
    logic        res1_valid;
    logic        res1_ready;
    logic [31:0] res1_data;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
               req1_valid, req1_a, req1_b, req1_op,
               core_result, res0_ready, res1_ready,
        output req0_ready, req1_ready, core_issue, core_a, core_b, core_op,
               res0_valid, res0_data, res1_valid, res1_data
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
               req1_valid, req1_a, req1_b, req1_op,
               core_result, res0_ready, res1_ready,
        input  req0_ready, req1_ready, core_issue, core_a, core_b, core_op,
               res0_valid, res0_data, res1_valid, res1_data
    );
endinterface

// File: rtl/fpaddsub_issue_arbiter.sv
// rtl/fpaddsub_issue_arbiter.sv - two-port round-robin issue arbiter and result router for a fixed-latency FP add/sub core
module fpaddsub_issue_arbiter #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fpaddsub_issue_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    logic [1:0]    req_valid, res_ready, has_credit, eligible, grant, accept;
    logic [1:0]    pop, wr_en, empty, full;
    logic [31:0]   req_a [2];
    logic [31:0]   req_b [2];
    logic [1:0]    req_op;

    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          ptr_q, ptr_d;

    logic          core_issue_q, core_id_q, core_op_q;
    logic [31:0]   core_a_q, core_b_q;

    logic [LAT-1:0] tag_v_q, tag_id_q;

    logic [31:0]   mem_q [2][DEPTH];
    logic [PW:0]   wr_ptr_q [2];
    logic [PW:0]   rd_ptr_q [2];

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign res_ready = {bus.res1_ready, bus.res0_ready};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;
    assign req_op    = {bus.req1_op, bus.req0_op};

    // A requester's grant never looks at its own valid, only at the rival's eligibility.
    always_comb begin
        has_credit = '0;
        for (int n = 0; n < 2; n++) begin
            has_credit[n] = cnt_q[n] < CREDITS;
        end
        eligible = req_valid & has_credit;
        grant[0] = !rst && has_credit[0] && (!eligible[1] || !ptr_q);
        grant[1] = !rst && has_credit[1] && (!eligible[0] || ptr_q);
        accept   = grant & req_valid;
        ptr_d    = ptr_q;
        if (accept[0]) begin
            ptr_d = 1'b1;
        end else if (accept[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_comb begin
        empty = '0;
        full  = '0;
        pop   = '0;
        wr_en = '0;
        for (int n = 0; n < 2; n++) begin
            cnt_d[n] = cnt_q[n];
            empty[n] = wr_ptr_q[n] == rd_ptr_q[n];
            full[n]  = (wr_ptr_q[n][PW] != rd_ptr_q[n][PW]) &&
                       (wr_ptr_q[n][PW-1:0] == rd_ptr_q[n][PW-1:0]);
            pop[n]   = !empty[n] && res_ready[n];
            wr_en[n] = tag_v_q[LAT-1] && (tag_id_q[LAT-1] == n[0]) && !full[n];
            if (accept[n] && !pop[n]) begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end else if (pop[n] && !accept[n]) begin
                cnt_d[n] = cnt_q[n] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            core_issue_q <= 1'b0;
            core_id_q    <= 1'b0;
            core_op_q    <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            for (int n = 0; n < 2; n++) begin
                cnt_q[n]    <= '0;
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            core_issue_q <= |accept;
            if (|accept) begin
                core_id_q <= accept[1];
                core_a_q  <= accept[1] ? req_a[1] : req_a[0];
                core_b_q  <= accept[1] ? req_b[1] : req_b[0];
                core_op_q <= accept[1] ? req_op[1] : req_op[0];
            end
            // Stage LAT-1 lines up with the cycle the core presents this op's result.
            tag_v_q[0]  <= core_issue_q;
            tag_id_q[0] <= core_id_q;
            for (int i = 1; i < LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            for (int n = 0; n < 2; n++) begin
                cnt_q[n] <= cnt_d[n];
                if (wr_en[n]) begin
                    wr_ptr_q[n] <= wr_ptr_q[n] + 1'b1;
                end
                if (pop[n]) begin
                    rd_ptr_q[n] <= rd_ptr_q[n] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[n][i] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (wr_en[n]) begin
                    mem_q[n][wr_ptr_q[n][PW-1:0]] <= bus.core_result;
                end
            end
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.core_issue = core_issue_q;
    assign bus.core_a     = core_a_q;
    assign bus.core_b     = core_b_q;
    assign bus.core_op    = core_op_q;
    assign bus.res0_valid = !empty[0];
    assign bus.res1_valid = !empty[1];
    assign bus.res0_data  = mem_q[0][rd_ptr_q[0][PW-1:0]];
    assign bus.res1_data  = mem_q[1][rd_ptr_q[1][PW-1:0]];
endmodule

// File: tb/tb_fpaddsub_issue_arbiter.sv
// tb/tb_fpaddsub_issue_arbiter.sv - randomized self-checking bench for fpaddsub_issue_arbiter
module tb_fpaddsub_issue_arbiter;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        int          due;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fpaddsub_issue_arbiter_if ifc ();

    fpaddsub_issue_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Core stand-in: single-precision add/sub through double arithmetic (normals and zero only).
    function automatic real sp2r(logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic op);
        real ra, rb;
        ra = sp2r(a);
        rb = sp2r(b);
        return r2sp(op ? ra - rb : ra + rb);
    endfunction

    function automatic logic [31:0] rnd_sp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom())};
    endfunction

    // Reference model state
    ent_t        q0[$];
    ent_t        q1[$];
    int          m_cnt [2];
    logic        m_ptr, m_iss, m_op;
    logic [31:0] m_a, m_b;
    int          obs_acc [2];
    int          obs_issue;
    int          obs_log[$];

    always @(negedge clk) begin : monitor
        logic [1:0] vv, rr, cred, elig, er, acc;
        logic       hv0, hv1;
        ent_t       e;
        if (ifc.req0_valid && ifc.req0_ready) begin
            obs_acc[0]++;
            obs_log.push_back(0);
        end
        if (ifc.req1_valid && ifc.req1_ready) begin
            obs_acc[1]++;
            obs_log.push_back(1);
        end
        if (ifc.core_issue) obs_issue++;
        if (rst) begin
            chk("rst_req0_ready", ifc.req0_ready, 0);
            chk("rst_req1_ready", ifc.req1_ready, 0);
            chk("rst_core_issue", ifc.core_issue, 0);
            chk("rst_core_a", ifc.core_a, 0);
            chk("rst_core_b", ifc.core_b, 0);
            chk("rst_core_op", ifc.core_op, 0);
            chk("rst_res0_valid", ifc.res0_valid, 0);
            chk("rst_res1_valid", ifc.res1_valid, 0);
            chk("rst_res0_data", ifc.res0_data, 0);
            chk("rst_res1_data", ifc.res1_data, 0);
            q0.delete();
            q1.delete();
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_ptr = 1'b0;
            m_iss = 1'b0;
            m_op  = 1'b0;
            m_a   = '0;
            m_b   = '0;
        end else begin
            vv = {ifc.req1_valid, ifc.req0_valid};
            rr = {ifc.res1_ready, ifc.res0_ready};
            cred[0] = m_cnt[0] < DEPTH;
            cred[1] = m_cnt[1] < DEPTH;
            elig = vv & cred;
            er[0] = cred[0] && (!elig[1] || m_ptr == 1'b0);
            er[1] = cred[1] && (!elig[0] || m_ptr == 1'b1);
            chk("req0_ready", ifc.req0_ready, er[0]);
            chk("req1_ready", ifc.req1_ready, er[1]);
            chk("core_issue", ifc.core_issue, m_iss);
            chk("core_a", ifc.core_a, m_a);
            chk("core_b", ifc.core_b, m_b);
            chk("core_op", ifc.core_op, m_op);
            hv0 = (q0.size() > 0) && (q0[0].due <= cyc);
            hv1 = (q1.size() > 0) && (q1[0].due <= cyc);
            chk("res0_valid", ifc.res0_valid, hv0);
            chk("res1_valid", ifc.res1_valid, hv1);
            if (hv0) chk("res0_data", ifc.res0_data, q0[0].d);
            if (hv1) chk("res1_data", ifc.res1_data, q1[0].d);
            acc = vv & er;
            if (hv0 && rr[0]) begin
                q0.delete(0);
                m_cnt[0]--;
            end
            if (hv1 && rr[1]) begin
                q1.delete(0);
                m_cnt[1]--;
            end
            m_iss = |acc;
            e.due = cyc + LAT + 2;
            if (acc[0]) begin
                e.d = fadd(ifc.req0_a, ifc.req0_b, ifc.req0_op);
                q0.push_back(e);
                m_cnt[0]++;
                m_a = ifc.req0_a;
                m_b = ifc.req0_b;
                m_op = ifc.req0_op;
                m_ptr = 1'b1;
            end else if (acc[1]) begin
                e.d = fadd(ifc.req1_a, ifc.req1_b, ifc.req1_op);
                q1.push_back(e);
                m_cnt[1]++;
                m_a = ifc.req1_a;
                m_b = ifc.req1_b;
                m_op = ifc.req1_op;
                m_ptr = 1'b0;
            end
        end
    end

    // Fixed-latency core: keeps emitting across resets, untagged cycles carry junk.
    logic [32:0] core_q[$];
    always @(negedge clk) begin : core_model
        logic [32:0] ce;
        if (core_q.size() == LAT) begin
            ce = core_q.pop_front();
            ifc.core_result = ce[32] ? ce[31:0] : $urandom();
        end else begin
            ifc.core_result = $urandom();
        end
        core_q.push_back({ifc.core_issue, fadd(ifc.core_a, ifc.core_b, ifc.core_op)});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        ifc.res0_ready = 1'b0;
        ifc.res1_ready = 1'b0;
    endtask

    task automatic rand_ops();
        ifc.req0_a  = rnd_sp();
        ifc.req0_b  = rnd_sp();
        ifc.req0_op = 1'($urandom_range(0, 1));
        ifc.req1_a  = rnd_sp();
        ifc.req1_b  = rnd_sp();
        ifc.req1_op = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_core_issue", ifc.core_issue, 0);
        chk("async_rst_req0_ready", ifc.req0_ready, 0);
        chk("async_rst_req1_ready", ifc.req1_ready, 0);
        chk("async_rst_res0_valid", ifc.res0_valid, 0);
        chk("async_rst_res1_valid", ifc.res1_valid, 0);
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int t, b0, b1;
        logic [31:0] first0;
        ifc.core_result = '0;
        idle_inputs();
        rand_ops();
        repeat (3) step();
        rst = 1'b0;

        // single op: 1.0 + 2.0 on requester 0
        step();
        ifc.res0_ready = 1'b1;
        ifc.res1_ready = 1'b1;
        ifc.req0_valid = 1'b1;
        ifc.req0_a = 32'h3F80_0000;
        ifc.req0_b = 32'h4000_0000;
        ifc.req0_op = 1'b0;
        t = cyc;
        at_neg(t);
        chk("single_req0_ready", ifc.req0_ready, 1);
        step();
        ifc.req0_valid = 1'b0;
        at_neg(t + 1);
        chk("single_core_issue", ifc.core_issue, 1);
        chk("single_core_a", ifc.core_a, 32'h3F80_0000);
        chk("single_core_b", ifc.core_b, 32'h4000_0000);
        chk("single_core_op", ifc.core_op, 0);
        at_neg(t + LAT + 1);
        chk("single_res0_early", ifc.res0_valid, 0);
        at_neg(t + LAT + 2);
        chk("single_res0_valid", ifc.res0_valid, 1);
        chk("single_res0_data", ifc.res0_data, 32'h4040_0000);
        chk("single_res1_valid", ifc.res1_valid, 0);
        step();

        // contention: alternate grants, one issue per cycle
        do_reset();
        obs_log.delete();
        b0 = obs_issue;
        ifc.res0_ready = 1'b1;
        ifc.res1_ready = 1'b1;
        ifc.req0_valid = 1'b1;
        ifc.req1_valid = 1'b1;
        repeat (40) begin
            rand_ops();
            step();
        end
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        step();
        chk("contention_issues", obs_issue - b0, 40);
        chk("contention_log_size", (obs_log.size() >= 8) ? 1 : 0, 1);
        for (int i = 0; i < 8; i++) chk("contention_grant_order", obs_log[i], i % 2);
        repeat (10) step();

        // backpressure on requester 1
        do_reset();
        b1 = obs_acc[1];
        ifc.req1_valid = 1'b1;
        repeat (20) begin
            rand_ops();
            step();
        end
        chk("bp_accepts", obs_acc[1] - b1, DEPTH);
        ifc.res1_ready = 1'b1;
        t = cyc;
        at_neg(t);
        chk("bp_res1_valid", ifc.res1_valid, 1);
        chk("bp_ready_at_pop", ifc.req1_ready, 0);
        step();
        ifc.res1_ready = 1'b0;
        at_neg(t + 1);
        chk("bp_ready_after_pop", ifc.req1_ready, 1);
        repeat (10) begin
            rand_ops();
            step();
        end
        chk("bp_accepts_after_pop", obs_acc[1] - b1, DEPTH + 1);

        // requester 0 stalled, requester 1 keeps flowing
        do_reset();
        b0 = obs_acc[0];
        b1 = obs_acc[1];
        ifc.req0_valid = 1'b1;
        ifc.req1_valid = 1'b1;
        ifc.res1_ready = 1'b1;
        rand_ops();
        first0 = fadd(ifc.req0_a, ifc.req0_b, ifc.req0_op);
        step();
        repeat (29) begin
            rand_ops();
            step();
        end
        chk("stall_req0_accepts", obs_acc[0] - b0, DEPTH);
        chk("stall_req1_progress", (obs_acc[1] - b1 > 8) ? 1 : 0, 1);
        chk("stall_res0_valid", ifc.res0_valid, 1);
        chk("stall_res0_head", ifc.res0_data, first0);

        // reset with results in flight and buffered
        do_reset();
        ifc.req0_valid = 1'b1;
        ifc.req1_valid = 1'b1;
        repeat (5) begin
            rand_ops();
            step();
        end
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
        step();
        step();
        chk("inflight_buffered", ifc.res0_valid, 1);
        do_reset();
        for (int i = 0; i < LAT + 2; i++) begin
            at_neg(cyc);
            chk("post_rst_res0_valid", ifc.res0_valid, 0);
            chk("post_rst_res1_valid", ifc.res1_valid, 0);
            step();
        end

        // random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            ifc.req0_valid = ($urandom_range(0, 3) != 0);
            ifc.req1_valid = ($urandom_range(0, 3) != 0);
            ifc.res0_ready = ($urandom_range(0, 2) != 0);
            ifc.res1_ready = ($urandom_range(0, 2) != 0);
            rand_ops();
            if ($urandom_range(0, 399) == 0) do_reset();
            else step();
        end
        idle_inputs();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
